// File: rtl/hex_scroll_pkg.sv
// Shared constants for the "dE1" scrolling display monitor: segment glyphs,
// symbol codes, the sync frame, the rotation phase limit and the state type.
package hex_scroll_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_D     = 7'h21;

  // 4-bit symbol codes recovered from the glyphs
  localparam logic [3:0] CODE_BLANK = 4'h0;
  localparam logic [3:0] CODE_ONE   = 4'h1;
  localparam logic [3:0] CODE_D     = 4'hD;
  localparam logic [3:0] CODE_E     = 4'hE;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  // Frame that (re)acquires lock: blank blank blank d E 1
  localparam logic [23:0] SYNC_PATTERN = 24'h000DE1;

  // Six digits, so the rotation phase runs 0..5
  localparam logic [2:0] PHASE_MAX = 3'd5;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_LOCKED = 1'b1
  } mon_state_t;

  // One-digit left rotation of a six-digit frame
  function automatic logic [23:0] rotl_digit(input logic [23:0] f);
    return {f[19:0], f[23:20]};
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps one active-low 7-segment pattern back to its symbol code.
// Unknown patterns return CODE_BAD with valid low.
module seg7_glyph_decode
  import hex_scroll_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       valid
);

  // Pure lookup; only the four glyphs the scroller emits are legal
  always_comb begin
    code  = CODE_BAD;
    valid = 1'b0;
    case (seg)
      SEG_BLANK: begin code = CODE_BLANK; valid = 1'b1; end
      SEG_ONE:   begin code = CODE_ONE;   valid = 1'b1; end
      SEG_E:     begin code = CODE_E;     valid = 1'b1; end
      SEG_D:     begin code = CODE_D;     valid = 1'b1; end
      default:   begin code = CODE_BAD;   valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/hex_scroll_monitor.sv
// Receive-side checker for the six-digit scrolling display. Debounces whole
// frames, decodes them and checks that each new frame is a one-digit left
// rotation of the previous one, reporting sync, step, phase and scroll period.
module hex_scroll_monitor
  import hex_scroll_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 26
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [6:0]       HEX5,
  input  logic [6:0]       HEX4,
  input  logic [6:0]       HEX3,
  input  logic [6:0]       HEX2,
  input  logic [6:0]       HEX1,
  input  logic [6:0]       HEX0,
  output logic [23:0]      codes_o,
  output logic             locked_o,
  output logic [2:0]       phase_o,
  output logic             frame_acc_o,
  output logic             step_o,
  output logic             sync_o,
  output logic             seq_err_o,
  output logic             glyph_err_o,
  output logic [CNT_W-1:0] period_o
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_FIRE = STAB_W'(STABLE_CYCLES - 1);

  logic [41:0]       hex_in;
  logic [41:0]       raw_q;
  logic [STAB_W-1:0] stab_cnt;
  logic              in_stable;
  logic              accept;

  logic [23:0]       frame_code;
  logic [5:0]        digit_valid;

  mon_state_t        state_reg, state_next;
  logic [23:0]       last_reg, last_next;
  logic [CNT_W-1:0]  interval_reg, interval_next, interval_plus;
  logic [23:0]       codes_next;
  logic [2:0]        phase_next;
  logic [CNT_W-1:0]  period_next;
  logic              frame_acc_next, step_next, sync_next, seq_err_next, glyph_err_next;

  assign hex_in    = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign in_stable = (hex_in == raw_q);
  // Fires exactly once per stable period because stab_cnt saturates past STAB_FIRE
  assign accept    = in_stable && (stab_cnt == STAB_FIRE);

  // Sample the segment buses and count how long they have held still
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      raw_q    <= {6{SEG_BLANK}};
      stab_cnt <= '0;
    end else begin
      raw_q <= hex_in;
      if (!in_stable)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Decode the sampled frame; on accept raw_q equals the live inputs
  for (genvar gi = 0; gi < 6; gi++) begin : g_dec
    seg7_glyph_decode u_dec (
      .seg   (raw_q[7*gi +: 7]),
      .code  (frame_code[4*gi +: 4]),
      .valid (digit_valid[gi])
    );
  end

  // Counting the accept cycle itself makes period_o equal the cycle spacing
  assign interval_plus = (interval_reg == '1) ? interval_reg : interval_reg + 1'b1;

  // Classify an accepted frame: next state, pulses and counter updates
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    codes_next     = codes_o;
    phase_next     = phase_o;
    period_next    = period_o;
    interval_next  = interval_plus;
    frame_acc_next = 1'b0;
    step_next      = 1'b0;
    sync_next      = 1'b0;
    seq_err_next   = 1'b0;
    glyph_err_next = 1'b0;
    if (accept) begin
      if (!(&digit_valid)) begin
        glyph_err_next = 1'b1;
      end else if (frame_code != last_reg) begin
        // A repeat of the last frame (glitch recovery) falls through silently
        last_next      = frame_code;
        codes_next     = frame_code;
        frame_acc_next = 1'b1;
        if (state_reg == ST_LOCKED && frame_code == rotl_digit(last_reg)) begin
          step_next     = 1'b1;
          phase_next    = (phase_o == PHASE_MAX) ? 3'd0 : phase_o + 3'd1;
          period_next   = interval_plus;
          interval_next = '0;
        end else if (frame_code == SYNC_PATTERN) begin
          sync_next     = 1'b1;
          phase_next    = 3'd0;
          state_next    = ST_LOCKED;
          period_next   = interval_plus;
          interval_next = '0;
        end else if (state_reg == ST_LOCKED) begin
          seq_err_next = 1'b1;
          state_next   = ST_UNSYNC;
        end
      end
    end
  end

  // Classifier state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      state_reg <= ST_UNSYNC;
    else
      state_reg <= state_next;
  end

  // Frame history, counters and registered event pulses
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      last_reg     <= '0;
      interval_reg <= '0;
      codes_o      <= '0;
      phase_o      <= '0;
      period_o     <= '0;
      frame_acc_o  <= 1'b0;
      step_o       <= 1'b0;
      sync_o       <= 1'b0;
      seq_err_o    <= 1'b0;
      glyph_err_o  <= 1'b0;
    end else begin
      last_reg     <= last_next;
      interval_reg <= interval_next;
      codes_o      <= codes_next;
      phase_o      <= phase_next;
      period_o     <= period_next;
      frame_acc_o  <= frame_acc_next;
      step_o       <= step_next;
      sync_o       <= sync_next;
      seq_err_o    <= seq_err_next;
      glyph_err_o  <= glyph_err_next;
    end
  end

  assign locked_o = (state_reg == ST_LOCKED);

endmodule
